// File: rtl/debug_view_ctrl.sv
// Two-word channel viewer: manual, auto-scrolling or frozen display of NCH channel words,
// with a debounced-by-synchronizer snapshot button and sticky per-channel change flags.
module debug_view_ctrl #(
   parameter int NCH        = 8,
   parameter int W          = 16,
   parameter int SCROLL_DIV = 25000000,
   localparam int SELW      = $clog2(NCH)
) (
   input  logic                clock,
   input  logic                reset_L,
   input  logic [NCH*W-1:0]    chData,
   input  logic [SELW-1:0]     sel,
   input  logic [1:0]          mode,
   input  logic                snap_L,
   output logic [W-1:0]        dispHi,
   output logic [W-1:0]        dispLo,
   output logic [SELW-1:0]     base,
   output logic                frozen,
   output logic [NCH-1:0]      changed,
   output logic [1:0]          dbg_state
);

   localparam int CW = $clog2(SCROLL_DIV);

   typedef enum logic [1:0] {
      ST_LIVE   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SELW-1:0]    base_q, base_d, base_p1;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;
   logic [NCH*W-1:0]   snap_q, snap_d, prev_q, src;
   logic               prev_valid_q;
   logic [NCH-1:0]     changed_q, changed_d, set_v, clr_v;
   logic               frozen_q, frozen_d;
   logic               s1_q, s2_q, s3_q;
   logic               snap_req, capture;

   always_comb begin
      unique case (mode)
         2'b01:   state_d = ST_SCROLL;
         2'b10:   state_d = ST_FROZEN;
         default: state_d = ST_LIVE;
      endcase

      base_p1 = base_q + SELW'(1);

      // Display reads through the pre-edge base, so a new base shows one edge later.
      src  = (state_q == ST_FROZEN) ? snap_q : chData;
      hi_d = src[int'(base_q)*W +: W];
      lo_d = src[int'(base_p1)*W +: W];

      base_d = sel;
      cnt_d  = '0;
      if (state_d == ST_SCROLL) begin
         base_d = base_q;
         if (state_q == ST_SCROLL) begin
            if (cnt_q == CW'(SCROLL_DIV - 1)) begin
               base_d = base_p1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // Falling edge of the synchronized button, or entry into FROZEN, both take one capture.
      snap_req = s3_q & ~s2_q;
      capture  = snap_req | ((state_q != ST_FROZEN) && (state_d == ST_FROZEN));
      snap_d   = capture ? chData : snap_q;

      set_v = '0;
      clr_v = '0;
      for (int i = 0; i < NCH; i++) begin
         set_v[i] = prev_valid_q && (chData[i*W +: W] != prev_q[i*W +: W]);
         clr_v[i] = (state_q != ST_FROZEN) &&
                    ((SELW'(i) == base_q) || (SELW'(i) == base_p1));
      end
      changed_d = (changed_q & ~clr_v) | set_v;

      frozen_d = (state_d == ST_FROZEN);
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= ST_LIVE;
         base_q       <= '0;
         cnt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         snap_q       <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         changed_q    <= '0;
         frozen_q     <= 1'b0;
         s1_q         <= 1'b1;
         s2_q         <= 1'b1;
         s3_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         snap_q       <= snap_d;
         prev_q       <= chData;
         prev_valid_q <= 1'b1;
         changed_q    <= changed_d;
         frozen_q     <= frozen_d;
         s1_q         <= snap_L;
         s2_q         <= s1_q;
         s3_q         <= s2_q;
      end
   end

   assign dispHi    = hi_q;
   assign dispLo    = lo_q;
   assign base      = base_q;
   assign frozen    = frozen_q;
   assign changed   = changed_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Bench for debug_view_ctrl: directed scenarios plus random traffic, checked by a
// reference model feeding an expected queue that a negedge monitor drains.
module tb_debug_view_ctrl;

   localparam int NCH  = 8;
   localparam int W    = 16;
   localparam int DIV  = 4;
   localparam int SELW = 3;
   localparam int EW   = 2*W + SELW + 1 + NCH;

   logic              clock = 1'b0;
   logic              reset_L;
   logic [NCH*W-1:0]  ch_data;
   logic [SELW-1:0]   sel;
   logic [1:0]        mode;
   logic              snap_L;
   logic [W-1:0]      disp_hi, disp_lo;
   logic [SELW-1:0]   base;
   logic              frozen;
   logic [NCH-1:0]    changed;
   logic [1:0]        dbg_state;

   logic [W-1:0]      ch_arr[NCH];
   int                checks = 0;
   int                failures = 0;
   logic [EW-1:0]     exp_q[$];

   debug_view_ctrl #(.NCH(NCH), .W(W), .SCROLL_DIV(DIV)) dut (
      .clock(clock), .reset_L(reset_L), .chData(ch_data), .sel(sel), .mode(mode),
      .snap_L(snap_L), .dispHi(disp_hi), .dispLo(disp_lo), .base(base),
      .frozen(frozen), .changed(changed), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < NCH; i++) ch_data[i*W +: W] = ch_arr[i];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: mode 0=live 1=scroll 2=frozen, plain integers and arrays
   int            m_state, m_base, m_cnt, m_pv;
   logic [W-1:0]  m_hi, m_lo;
   logic [W-1:0]  m_snap[NCH];
   logic [W-1:0]  m_prev[NCH];
   logic [NCH-1:0] m_chg;
   logic          samp[$];   // sampled button levels, most recent first

   always @(posedge clock) begin : model
      int nxt, b1;
      logic req;
      if (!reset_L) begin
         m_state = 0; m_base = 0; m_cnt = 0; m_pv = 0;
         m_hi = '0; m_lo = '0; m_chg = '0;
         for (int i = 0; i < NCH; i++) begin m_snap[i] = '0; m_prev[i] = '0; end
         samp = '{1'b1, 1'b1, 1'b1};
      end else begin
         nxt = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
         b1  = (m_base + 1) % NCH;
         m_hi = (m_state == 2) ? m_snap[m_base] : ch_arr[m_base];
         m_lo = (m_state == 2) ? m_snap[b1]     : ch_arr[b1];
         for (int i = 0; i < NCH; i++) begin
            if (m_pv != 0 && ch_arr[i] != m_prev[i]) m_chg[i] = 1'b1;
            else if (m_state != 2 && (i == m_base || i == b1)) m_chg[i] = 1'b0;
         end
         // button went low two samples ago after being high three samples ago
         req = (samp[1] == 1'b0) && (samp[2] == 1'b1);
         if (req || (m_state != 2 && nxt == 2))
            for (int i = 0; i < NCH; i++) m_snap[i] = ch_arr[i];
         if (nxt == 1) begin
            if (m_state == 1) begin
               m_cnt++;
               if (m_cnt == DIV) begin m_cnt = 0; m_base = b1; end
            end else m_cnt = 0;
         end else begin
            m_base = int'(sel);
            m_cnt  = 0;
         end
         m_state = nxt;
         for (int i = 0; i < NCH; i++) m_prev[i] = ch_arr[i];
         m_pv = 1;
         samp.push_front(snap_L);
         void'(samp.pop_back());
      end
      exp_q.push_back({m_hi, m_lo, SELW'(m_base), (m_state == 2), m_chg});
   end

   // scoreboard monitor
   always @(negedge clock) begin : monitor
      logic [EW-1:0] e;
      logic [W-1:0] eh, el;
      logic [SELW-1:0] eb;
      logic ef;
      logic [NCH-1:0] ec;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {eh, el, eb, ef, ec} = e;
         check("sb_dispHi", 32'(disp_hi), 32'(eh));
         check("sb_dispLo", 32'(disp_lo), 32'(el));
         check("sb_base", 32'(base), 32'(eb));
         check("sb_frozen", 32'(frozen), 32'(ef));
         check("sb_changed", 32'(changed), 32'(ec));
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_dispHi"}, 32'(disp_hi), 32'h0);
      check({nm, "_dispLo"}, 32'(disp_lo), 32'h0);
      check({nm, "_base"}, 32'(base), 32'h0);
      check({nm, "_frozen"}, 32'(frozen), 32'h0);
      check({nm, "_changed"}, 32'(changed), 32'h0);
   endtask

   initial begin
      reset_L = 1'b0;
      sel = '0;
      mode = 2'b00;
      snap_L = 1'b1;
      for (int i = 0; i < NCH; i++) ch_arr[i] = W'(16'h1000 + i);
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock); #1 reset_L = 1'b1;
      ticks(2);

      // live manual with wrap
      sel = 3'd5;
      tick();
      check("live_base", 32'(base), 32'd5);
      tick();
      check("live_hi", 32'(disp_hi), 32'h1005);
      check("live_lo", 32'(disp_lo), 32'h1006);
      sel = 3'd7;
      ticks(2);
      check("wrap_hi", 32'(disp_hi), 32'h1007);
      check("wrap_lo", 32'(disp_lo), 32'h1000);

      // auto-scroll from base 6
      sel = 3'd6;
      ticks(2);
      mode = 2'b01;
      tick();
      ticks(3);
      check("scroll_hold6", 32'(base), 32'd6);
      tick();
      check("scroll_7", 32'(base), 32'd7);
      ticks(4);
      check("scroll_0", 32'(base), 32'd0);
      ticks(4);
      check("scroll_1", 32'(base), 32'd1);
      mode = 2'b00;
      sel = 3'd2;
      tick();
      check("scroll_exit", 32'(base), 32'd2);

      // freeze, single pulse, long hold
      tick();
      mode = 2'b10;
      tick();
      ch_arr[2] = 16'hBEEF;
      ticks(2);
      check("frz_hi", 32'(disp_hi), 32'h1002);
      check("frz_flag", 32'(frozen), 32'h1);
      snap_L = 1'b0;
      tick();
      snap_L = 1'b1;
      ticks(4);
      check("frz_pulse", 32'(disp_hi), 32'hBEEF);
      ch_arr[2] = 16'hCAFE;
      snap_L = 1'b0;
      ticks(3);
      ch_arr[2] = 16'h1234;
      ticks(17);
      snap_L = 1'b1;
      ticks(3);
      check("frz_once", 32'(disp_hi), 32'hCAFE);
      mode = 2'b00;
      ch_arr[2] = 16'h1002;

      // change flags
      sel = 3'd0;
      ticks(3);
      ch_arr[4] = ch_arr[4] ^ 16'h0001;
      tick();
      check("chg_set", 32'(changed[4]), 32'h1);
      ticks(2);
      check("chg_sticky", 32'(changed[4]), 32'h1);
      sel = 3'd3;
      ticks(2);
      check("chg_clear", 32'(changed[4]), 32'h0);
      sel = 3'd0;
      ticks(2);
      ch_arr[4] = ch_arr[4] ^ 16'h0001;
      tick();
      sel = 3'd3;
      tick();
      ch_arr[4] = ch_arr[4] ^ 16'h0001;
      tick();
      check("chg_setwins", 32'(changed[4]), 32'h1);
      tick();
      check("chg_clear2", 32'(changed[4]), 32'h0);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) sel = SELW'($urandom_range(0, NCH - 1));
         if ($urandom_range(0, 2) == 0) ch_arr[$urandom_range(0, NCH - 1)] = W'($urandom);
         if ($urandom_range(0, 9) == 0) snap_L = ~snap_L;
         tick();
      end

      // reset in the middle of a scroll step
      snap_L = 1'b1;
      mode = 2'b00;
      sel = 3'd3;
      for (int i = 0; i < NCH; i++) ch_arr[i] = W'(16'h1000 + i);
      ticks(3);
      mode = 2'b01;
      ticks(3);
      check("pre_rst_base", 32'(base), 32'd3);
      @(negedge clock);
      #1 reset_L = 1'b0;
      #1;
      check_all_zero("async_rst");
      for (int i = 0; i < NCH; i++) ch_arr[i] = W'($urandom_range(1, 65535));
      repeat (2) @(negedge clock);
      #1;
      reset_L = 1'b1;
      mode = 2'b00;
      sel = 3'd0;
      tick();
      check("rst_nochg", 32'(changed), 32'h0);
      ticks(5);

      repeat (3) @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
